// File: rtl/conv_input_feeder.sv
//-----------------------------------------------------------------------------
// conv_input_feeder
//
// Upstream feeder for the 1xARRAY_SIZE convolution kernel array. It loads one
// IMAGE_SIZE x IMAGE_SIZE image and one KERNEL_SIZE x KERNEL_SIZE weight set
// through two independent valid/ready ports. It then streams KERNEL_SIZE^2
// beats per output row. Each beat carries an ARRAY_SIZE-wide horizontal pixel
// slice and the single weight that the kernel array multiplies against every
// slot. After the last row it pulses o_done for one cycle and reopens the
// load ports.
//
// Parameters
//   WIDTH        pixel / weight word width
//   KERNEL_SIZE  kernel edge
//   IMAGE_SIZE   image edge
//   ARRAY_SIZE   output columns per beat (IMAGE_SIZE - KERNEL_SIZE + 1)
//
// Ports
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   i_pixel_valid/i_pixel           raster-order pixel load stream
//   o_pixel_ready                   pixel beat accepted when valid & ready
//   i_weight_valid/i_weight         raster-order weight load stream
//   o_weight_ready                  weight beat accepted when valid & ready
//   o_pixel_bus                     ARRAY_SIZE pixel slots, slot 0 in the MSBs
//   o_weight                        broadcast weight for the current beat
//   o_valid                         beat valid
//   o_first / o_last                first / last tap of an output row
//   o_row                           output row of the current beat
//   o_done                          one-cycle pulse after the final beat
//-----------------------------------------------------------------------------
module conv_input_feeder #(
    parameter int WIDTH       = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 8,
    parameter int ARRAY_SIZE  = 6
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          i_pixel_valid,
    input  logic [WIDTH-1:0]              i_pixel,
    output logic                          o_pixel_ready,

    input  logic                          i_weight_valid,
    input  logic [WIDTH-1:0]              i_weight,
    output logic                          o_weight_ready,

    output logic [ARRAY_SIZE*WIDTH-1:0]   o_pixel_bus,
    output logic [WIDTH-1:0]              o_weight,
    output logic                          o_valid,
    output logic                          o_first,
    output logic                          o_last,
    output logic [$clog2(ARRAY_SIZE)-1:0] o_row,
    output logic                          o_done
);

    localparam int PIX_N  = IMAGE_SIZE * IMAGE_SIZE;
    localparam int WT_N   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PIX_AW = $clog2(PIX_N);
    localparam int PIX_CW = $clog2(PIX_N + 1);
    localparam int WT_AW  = $clog2(WT_N);
    localparam int WT_CW  = $clog2(WT_N + 1);
    localparam int KW     = $clog2(KERNEL_SIZE);
    localparam int ROW_W  = $clog2(ARRAY_SIZE);

    localparam logic [PIX_CW-1:0] PIX_FULL = PIX_CW'(PIX_N);
    localparam logic [WT_CW-1:0]  WT_FULL  = WT_CW'(WT_N);
    localparam logic [WT_AW-1:0]  TAP_LAST = WT_AW'(WT_N - 1);
    localparam logic [KW-1:0]     K_LAST   = KW'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ARRAY_SIZE - 1);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t state;

    // Image and weight storage; never cleared, every load overwrites it fully
    logic [WIDTH-1:0] pix_mem [PIX_N];
    logic [WIDTH-1:0] wt_mem  [WT_N];

    // Load counters double as write addresses
    logic [PIX_CW-1:0] pix_cnt;
    logic [WT_CW-1:0]  wt_cnt;
    logic [PIX_CW-1:0] pix_cnt_nxt;
    logic [WT_CW-1:0]  wt_cnt_nxt;
    logic              pix_acc;
    logic              wt_acc;

    // Stream position: row r, tap t, with (ky, kx) tracking t so that no
    // divider is needed to split the tap into kernel coordinates
    logic [ROW_W-1:0] r;
    logic [WT_AW-1:0] t;
    logic [KW-1:0]    ky;
    logic [KW-1:0]    kx;

    // Pixel slice for the current (r, t), gathered from storage
    logic [PIX_AW-1:0]           slot_idx [ARRAY_SIZE];
    logic [ARRAY_SIZE*WIDTH-1:0] slot_bus;

    // Ready is purely a function of state and counters, so it is glitch-free
    // and drops the same cycle a counter reaches its full value
    assign o_pixel_ready  = (state == LOAD) && (pix_cnt < PIX_FULL);
    assign o_weight_ready = (state == LOAD) && (wt_cnt < WT_FULL);

    assign pix_acc = i_pixel_valid  && o_pixel_ready;
    assign wt_acc  = i_weight_valid && o_weight_ready;

    assign pix_cnt_nxt = pix_cnt + PIX_CW'(pix_acc);
    assign wt_cnt_nxt  = wt_cnt  + WT_CW'(wt_acc);

    // Slot j reads pixel[r+ky][j+kx]; slot 0 lands in the MSBs of the bus
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_slot
        assign slot_idx[j] = PIX_AW'((int'(r) + int'(ky)) * IMAGE_SIZE + j + int'(kx));
        assign slot_bus[(ARRAY_SIZE-j)*WIDTH-1 -: WIDTH] = pix_mem[slot_idx[j]];
    end

    // Storage writes happen on accepted load beats only; no reset is needed
    // because a full load always precedes any read of the contents
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            pix_mem[pix_cnt[PIX_AW-1:0]] <= i_pixel;
        end
        if (wt_acc) begin
            wt_mem[wt_cnt[WT_AW-1:0]] <= i_weight;
        end
    end

    // Control FSM and registered beat outputs. Outputs default to zero every
    // cycle so that all beat fields read 0 whenever o_valid is low. LOAD hands
    // over to RUN on the edge that fills the second of the two counters, so
    // beat 0 is registered on the following edge. RUN walks tap-major within a
    // row and row-major overall, then DONE spends one cycle pulsing o_done and
    // reopening the load ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            pix_cnt     <= '0;
            wt_cnt      <= '0;
            r           <= '0;
            t           <= '0;
            ky          <= '0;
            kx          <= '0;
            o_pixel_bus <= '0;
            o_weight    <= '0;
            o_valid     <= 1'b0;
            o_first     <= 1'b0;
            o_last      <= 1'b0;
            o_row       <= '0;
            o_done      <= 1'b0;
        end else begin
            o_pixel_bus <= '0;
            o_weight    <= '0;
            o_valid     <= 1'b0;
            o_first     <= 1'b0;
            o_last      <= 1'b0;
            o_row       <= '0;
            o_done      <= 1'b0;

            case (state)
                LOAD: begin
                    pix_cnt <= pix_cnt_nxt;
                    wt_cnt  <= wt_cnt_nxt;
                    if ((pix_cnt_nxt == PIX_FULL) && (wt_cnt_nxt == WT_FULL)) begin
                        state <= RUN;
                        r     <= '0;
                        t     <= '0;
                        ky    <= '0;
                        kx    <= '0;
                    end
                end

                RUN: begin
                    o_valid     <= 1'b1;
                    o_first     <= (t == '0);
                    o_last      <= (t == TAP_LAST);
                    o_row       <= r;
                    o_weight    <= wt_mem[t];
                    o_pixel_bus <= slot_bus;

                    if (t == TAP_LAST) begin
                        t  <= '0;
                        ky <= '0;
                        kx <= '0;
                        if (r == ROW_LAST) begin
                            state <= DONE;
                        end else begin
                            r <= r + ROW_W'(1);
                        end
                    end else begin
                        t <= t + WT_AW'(1);
                        if (kx == K_LAST) begin
                            kx <= '0;
                            ky <= ky + KW'(1);
                        end else begin
                            kx <= kx + KW'(1);
                        end
                    end
                end

                DONE: begin
                    o_done  <= 1'b1;
                    pix_cnt <= '0;
                    wt_cnt  <= '0;
                    state   <= LOAD;
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_input_feeder.sv
//-----------------------------------------------------------------------------
// tb_conv_input_feeder
//
// Self-checking bench for conv_input_feeder. Every load pushes the full set of
// expected beats and per-row convolution sums onto queues; a negedge monitor
// pops and compares them whenever the DUT presents a beat, checks that idle
// outputs are zero, and checks that o_done follows the final beat by exactly
// one cycle. Directed sequences cover the fixed-pattern load, weights-first
// loading with gaps, reset mid-stream and loading held across a stream.
//-----------------------------------------------------------------------------
module tb_conv_input_feeder;

    localparam int W = 32;
    localparam int K = 3;
    localparam int N = 8;
    localparam int A = 6;

    typedef struct packed {
        logic [A*W-1:0] bus;
        logic [W-1:0]   weight;
        logic           first;
        logic           last;
        logic [2:0]     row;
    } beat_t;

    logic           clk;
    logic           rst;
    logic           i_pixel_valid;
    logic [W-1:0]   i_pixel;
    logic           o_pixel_ready;
    logic           i_weight_valid;
    logic [W-1:0]   i_weight;
    logic           o_weight_ready;
    logic [A*W-1:0] o_pixel_bus;
    logic [W-1:0]   o_weight;
    logic           o_valid;
    logic           o_first;
    logic           o_last;
    logic [2:0]     o_row;
    logic           o_done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] img_model [N*N];
    logic [W-1:0] wt_model  [K*K];

    beat_t          exp_q  [$];
    logic [A*W-1:0] conv_q [$];

    bit             mon_en   = 0;
    bit             done_exp = 0;
    logic [A*W-1:0] acc_bus;

    conv_input_feeder #(
        .WIDTH(W), .KERNEL_SIZE(K), .IMAGE_SIZE(N), .ARRAY_SIZE(A)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pixel_valid  (i_pixel_valid),
        .i_pixel        (i_pixel),
        .o_pixel_ready  (o_pixel_ready),
        .i_weight_valid (i_weight_valid),
        .i_weight       (i_weight),
        .o_weight_ready (o_weight_ready),
        .o_pixel_bus    (o_pixel_bus),
        .o_weight       (o_weight),
        .o_valid        (o_valid),
        .o_first        (o_first),
        .o_last         (o_last),
        .o_row          (o_row),
        .o_done         (o_done)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream of the bounded waits misbehaves
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Six consecutive integers starting at base, slot 0 in the MSBs
    function automatic logic [A*W-1:0] mkBus(input int base);
        logic [A*W-1:0] b;
        b = '0;
        for (int j = 0; j < A; j++) b[(A-j)*W-1 -: W] = W'(base + j);
        return b;
    endfunction

    task automatic setPatternModel();
        for (int i = 0; i < N*N; i++) img_model[i] = W'(i);
        for (int i = 0; i < K*K; i++) wt_model[i]  = W'(i + 1);
    endtask

    task automatic setRandomModel();
        for (int i = 0; i < N*N; i++) img_model[i] = $urandom();
        for (int i = 0; i < K*K; i++) wt_model[i]  = $urandom();
    endtask

    // Queue every beat of the coming stream plus each row's convolution result
    task automatic pushExpected();
        beat_t          b;
        logic [A*W-1:0] sums;
        logic [W-1:0]   px;
        int             ky, kx;
        for (int r = 0; r < A; r++) begin
            sums = '0;
            for (int t = 0; t < K*K; t++) begin
                ky = t / K;
                kx = t % K;
                b  = '0;
                for (int j = 0; j < A; j++) begin
                    px = img_model[(r+ky)*N + j + kx];
                    b.bus[(A-j)*W-1 -: W]  = px;
                    sums[(A-j)*W-1 -: W]   = sums[(A-j)*W-1 -: W] + px * wt_model[t];
                end
                b.weight = wt_model[t];
                b.first  = (t == 0);
                b.last   = (t == K*K-1);
                b.row    = 3'(r);
                exp_q.push_back(b);
            end
            conv_q.push_back(sums);
        end
    endtask

    // Drive one full load of img_model/wt_model. Returns 1 ns after the edge
    // that accepts the final item. With weights_first the pixels wait until
    // all weights are in, and a bogus 10th weight stays offered meanwhile.
    task automatic applyStimulus(input int gap_pct, input bit weights_first,
                                 input bit hold_after);
        int pi, wi, cyc;
        bit pacc, wacc, extra_checked;
        pi = 0; wi = 0; cyc = 0; extra_checked = 0;
        while ((pi < N*N || wi < K*K) && cyc < 2000) begin
            if (wi < K*K) begin
                i_weight_valid = 1'b1;
                i_weight       = wt_model[wi];
            end else if (weights_first) begin
                i_weight_valid = 1'b1;
                i_weight       = 32'hDEAD_BEEF;
                if (!extra_checked) begin
                    checkOutput("wt_ready_after_9", 256'(o_weight_ready), 256'(0));
                    extra_checked = 1;
                end
            end else begin
                i_weight_valid = 1'b0;
            end
            if (pi < N*N && (!weights_first || wi == K*K) &&
                int'($urandom_range(99)) >= gap_pct) begin
                i_pixel_valid = 1'b1;
                i_pixel       = img_model[pi];
            end else begin
                i_pixel_valid = 1'b0;
            end
            pacc = i_pixel_valid  && o_pixel_ready;
            wacc = i_weight_valid && o_weight_ready;
            @(posedge clk); #1;
            if (pacc) pi++;
            if (wacc) wi++;
            cyc++;
        end
        if (cyc >= 2000) checkOutput("load_timeout", 256'(0), 256'(1));
        pushExpected();
        if (!hold_after) begin
            i_pixel_valid  = 1'b0;
            i_weight_valid = 1'b0;
        end
    endtask

    task automatic waitDone();
        int cyc;
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 200) checkOutput("done_timeout", 256'(0), 256'(1));
    endtask

    // Scoreboard monitor, sampling on the falling edge away from updates
    always @(negedge clk) begin
        beat_t          act, e;
        logic [A*W-1:0] exp_sums;
        if (mon_en) begin
            checkOutput("done_timing", 256'(o_done), 256'(done_exp));
            done_exp = 0;
            act = {o_pixel_bus, o_weight, o_first, o_last, o_row};
            if (o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 256'(act), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat", 256'(act), 256'(e));
                    if (e.row == 3'(A-1) && e.last) done_exp = 1;
                end
                if (o_first) acc_bus = '0;
                for (int j = 0; j < A; j++)
                    acc_bus[(A-j)*W-1 -: W] = acc_bus[(A-j)*W-1 -: W] +
                                              o_pixel_bus[(A-j)*W-1 -: W] * o_weight;
                if (o_last) begin
                    if (conv_q.size() == 0) begin
                        checkOutput("unexpected_row", 256'(acc_bus), 256'(0));
                    end else begin
                        exp_sums = conv_q.pop_front();
                        checkOutput("conv_row", 256'(acc_bus), 256'(exp_sums));
                    end
                end
            end else begin
                checkOutput("idle_zero", 256'(act), 256'(0));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        i_pixel_valid  = 1'b0;
        i_pixel        = '0;
        i_weight_valid = 1'b0;
        i_weight       = '0;
        acc_bus        = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_valid", 256'(o_valid), 256'(0));
        checkOutput("reset_pix_ready", 256'(o_pixel_ready), 256'(1));
        checkOutput("reset_wt_ready", 256'(o_weight_ready), 256'(1));
        mon_en = 1;

        // Fixed pattern: pixel = y*8+x, w[t] = t+1, loaded in parallel
        $display("[TB] pattern load");
        setPatternModel();
        applyStimulus(0, 0, 0);
        @(posedge clk); #1;
        checkOutput("b0_bus", 256'(o_pixel_bus), 256'(mkBus(0)));
        checkOutput("b0_weight", 256'(o_weight), 256'(1));
        checkOutput("b0_first_row", 256'({o_valid, o_first, o_last, o_row}), 256'({1'b1, 1'b1, 1'b0, 3'd0}));
        repeat (8) @(posedge clk);
        #1;
        checkOutput("b8_bus", 256'(o_pixel_bus), 256'(mkBus(18)));
        checkOutput("b8_weight", 256'(o_weight), 256'(9));
        checkOutput("b8_last", 256'({o_first, o_last}), 256'({1'b0, 1'b1}));
        repeat (45) @(posedge clk);
        #1;
        checkOutput("b53_bus", 256'(o_pixel_bus), 256'(mkBus(58)));
        checkOutput("b53_row_last", 256'({o_valid, o_last, o_row}), 256'({1'b1, 1'b1, 3'd5}));
        @(posedge clk); #1;
        checkOutput("done_cycle", 256'({o_valid, o_done, o_pixel_ready, o_weight_ready}),
                    256'({1'b0, 1'b1, 1'b1, 1'b1}));
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 256'(o_done), 256'(0));

        // Weights first, then gappy pixels; RUN follows the 64th pixel by one edge
        $display("[TB] weights first with gaps");
        setRandomModel();
        applyStimulus(40, 1, 0);
        checkOutput("pre_run_valid", 256'(o_valid), 256'(0));
        @(posedge clk); #1;
        checkOutput("run_start_valid", 256'({o_valid, o_first}), 256'({1'b1, 1'b1}));
        waitDone();

        // Reset in the middle of a stream, then a fresh load
        $display("[TB] reset mid-stream");
        @(posedge clk); #1;
        setRandomModel();
        applyStimulus(0, 0, 0);
        repeat (21) @(posedge clk);
        #1;
        checkOutput("beat20_valid", 256'(o_valid), 256'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_outputs",
                    256'({o_valid, o_first, o_last, o_done, o_row, o_pixel_bus, o_weight}), 256'(0));
        checkOutput("rst_readys", 256'({o_pixel_ready, o_weight_ready}), 256'(2'b11));
        exp_q.delete();
        conv_q.delete();
        setRandomModel();
        applyStimulus(20, 0, 0);
        waitDone();

        // Valid held across a stream: nothing accepted until the o_done cycle
        $display("[TB] load held during stream");
        @(posedge clk); #1;
        setRandomModel();
        applyStimulus(0, 0, 1);
        setRandomModel();
        i_pixel_valid  = 1'b1;
        i_pixel        = img_model[0];
        i_weight_valid = 1'b1;
        i_weight       = wt_model[0];
        for (int c = 0; c < 200; c++) begin
            if (o_pixel_ready || o_weight_ready) break;
            @(posedge clk); #1;
        end
        checkOutput("ready_only_at_done", 256'(o_done), 256'(1));
        applyStimulus(10, 0, 0);
        waitDone();

        @(posedge clk); #1;
        checkOutput("queue_empty", 256'(exp_q.size() + conv_q.size()), 256'(0));
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_input_feeder.md
# conv_input_feeder

Upstream feeder for the 1×6 convolution kernel array. It serially loads one IMAGE_SIZE×IMAGE_SIZE image and one KERNEL_SIZE×KERNEL_SIZE weight set. It then streams, for every output row, KERNEL_SIZE² beats, each carrying one ARRAY_SIZE-wide pixel slice and the matching broadcast weight. The kernel array accumulates these beats into one row of convolution outputs.

## Interface
- WIDTH, 32, pixel/weight word width
- KERNEL_SIZE, 3, kernel edge (3×3 taps)
- IMAGE_SIZE, 8, image edge
- ARRAY_SIZE, 6, output columns per beat; must equal IMAGE_SIZE-KERNEL_SIZE+1
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- i_pixel_valid  in  1  pixel load beat valid
- i_pixel  in  WIDTH  image pixel, raster order (row 0 col 0 first)
- o_pixel_ready  out  1  pixel load beat accepted when valid&ready
- i_weight_valid  in  1  weight load beat valid
- i_weight  in  WIDTH  kernel weight, raster order w[ky*KERNEL_SIZE+kx]
- o_weight_ready  out  1  weight beat accepted when valid&ready
- o_pixel_bus  out  ARRAY_SIZE*WIDTH  slot j at bits [(ARRAY_SIZE-j)*WIDTH-1:(ARRAY_SIZE-j-1)*WIDTH]; slot 0 in MSBs
- o_weight  out  WIDTH  weight for current beat
- o_valid  out  1  beat valid
- o_first  out  1  first tap of an output row (kernel clears accumulator)
- o_last  out  1  last tap of an output row (kernel result complete next cycle)
- o_row  out  $clog2(ARRAY_SIZE)  output row index of current beat
- o_done  out  1  one-cycle pulse when the whole image has been streamed

## Operation
- Storage: IMAGE_SIZE² pixel registers and KERNEL_SIZE² weight registers. Load counters pix_cnt and wt_cnt.
- FSM states: LOAD, RUN, DONE.
- LOAD:
  - o_pixel_ready = (pix_cnt < IMAGE_SIZE²); o_weight_ready = (wt_cnt < KERNEL_SIZE²). Both are combinational from registers.
  - The two ports are independent and may both accept in the same cycle.
  - Each accepted beat writes storage[cnt] and increments cnt.
  - Beats offered while the corresponding counter is full are ignored (ready is low).
  - When both counters are full after an edge, the FSM enters RUN with r=0 and t=0. Both ready outputs are low in RUN and DONE.
- RUN:
  - Each cycle emits a beat for row r and tap t, with ky=t/KERNEL_SIZE and kx=t%KERNEL_SIZE.
  - Slot j = pixel[r+ky][j+kx]; o_weight = w[t].
  - o_first = (t==0); o_last = (t==KERNEL_SIZE²-1); o_row = r.
  - t increments each cycle; at t=KERNEL_SIZE²-1 it wraps to 0 and r increments.
  - After r=ARRAY_SIZE-1, t=KERNEL_SIZE²-1, the FSM goes to DONE.
  - There is no downstream backpressure; the stream is gap-free.
- DONE:
  - One cycle. o_done=1.
  - pix_cnt and wt_cnt clear, and the FSM returns to LOAD.
  - Storage contents are not cleared; the next load overwrites them.
- When o_valid=0, o_pixel_bus, o_weight, o_first, o_last and o_row are driven 0.
- Reset (any state, including mid-RUN):
  - All outputs registered to 0 on the next edge: o_valid, o_first, o_last, o_done, o_row, o_pixel_bus, o_weight.
  - Counters cleared; FSM = LOAD; o_pixel_ready=o_weight_ready=1 in the cycle after reset.
  - A partial stream is abandoned without o_done.
- Pure data movement; no arithmetic on pixel/weight values.

## Timing
- All beat outputs are registered.
- Let E be the edge accepting the final outstanding load item.
  - o_valid is high for the ARRAY_SIZE·KERNEL_SIZE² cycles (54 at defaults) following edges E+1 … E+54.
  - o_done is high in the cycle after edge E+55, and ready reasserts in that same cycle.
- Minimum turnaround: 64 pixel cycles (weights loaded in parallel) + 54 stream cycles + 1 DONE cycle.
- o_first and o_last are never high together (KERNEL_SIZE ≥ 2).
- o_valid stays high continuously from a row's o_last to the next row's o_first.

## Test plan
- Reset, then load pixel[y][x]=y*8+x and w[t]=t+1 → beat 0: slots 0..5 = 0..5, o_weight=1, o_first=1, o_row=0.
- Same load → beat 8: slots = 18..23, o_weight=9, o_last=1. Beat 53: o_row=5, slots = 58..63, o_last=1. o_done pulses exactly one cycle after beat 53.
- Load weights first, then pixels with random valid gaps → RUN starts exactly one edge after the 64th pixel is accepted. A 10th weight offered during LOAD is not accepted (o_weight_ready=0 after 9 accepted).
- Assert rst at beat 20 → next cycle: all outputs 0, both readys 1, no o_done. A fresh full load then streams correctly from beat 0.
- Load while o_valid is high (valid held during RUN) → no beat accepted until the cycle o_done is high. A second image then streams and matches the golden model.
- Golden check: accumulate Σ slot·weight over each row's 9 beats and compare against a software 3×3 valid convolution for random 32-bit integer data.
